// File: rtl/event_xbar_pkg.sv
// -----------------------------------------------------------------------------
// event_xbar_pkg
// Shared types for the PMU event crossbar.
//   xbar_mode_t    : per-channel output mode (level / rise / fall / off)
//   xbar_cfg_t     : one channel's routing config {sel, mode}
//   xbar_reset_cfg : identity-map config for a channel (sel = ch mod n_in)
// The select field is sized to a fixed maximum width so the struct can be
// shared by every parameterisation; the top only ever stores values that
// fit in its own SEL_W.
// -----------------------------------------------------------------------------
package event_xbar_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_RISE  = 2'b01,
      MODE_FALL  = 2'b10,
      MODE_OFF   = 2'b11
   } xbar_mode_t;

   // Largest source-select width supported (N_IN up to 1024).
   localparam int unsigned XBAR_SEL_MAX_W = 10;

   typedef struct packed {
      logic [XBAR_SEL_MAX_W-1:0] sel;
      xbar_mode_t                mode;
   } xbar_cfg_t;

   function automatic xbar_cfg_t xbar_reset_cfg(input int unsigned ch,
                                                input int unsigned n_in);
      xbar_cfg_t c;
      c.sel  = XBAR_SEL_MAX_W'(ch % n_in);
      c.mode = MODE_LEVEL;
      return c;
   endfunction

endpackage

// File: rtl/event_xbar_ch.sv
// -----------------------------------------------------------------------------
// event_xbar_ch
// One output channel of the event crossbar: source mux, edge-detect history
// and the registered output.
// Ports:
//   clk_i    : clock, rising edge
//   rstn_i   : synchronous active-low reset
//   event_i  : SoC event vector
//   cfg_i    : active {sel, mode} for this channel
//   commit_i : config commit strobe; the map changes on this edge
//   event_o  : registered routed event for this channel
// -----------------------------------------------------------------------------
module event_xbar_ch
   import event_xbar_pkg::*;
#(
   parameter int unsigned N_IN = 32
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic [N_IN-1:0] event_i,
   input  xbar_cfg_t       cfg_i,
   input  logic            commit_i,
   output logic            event_o
);

   logic mux;
   logic prev_q;
   logic armed_q;
   logic event_q;
   logic event_d;

   // Selects beyond the last source read as constant 0.
   always_comb begin
      mux = 1'b0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (cfg_i.sel == XBAR_SEL_MAX_W'(i)) begin
            mux = event_i[i];
         end
      end
   end

   always_comb begin
      event_d = 1'b0;
      case (cfg_i.mode)
         MODE_LEVEL: event_d = mux;
         MODE_RISE:  event_d = mux & ~prev_q & armed_q;
         MODE_FALL:  event_d = ~mux & prev_q & armed_q;
         MODE_OFF:   event_d = 1'b0;
         default:    event_d = 1'b0;
      endcase
   end

   // armed drops for one cycle after a commit (and after reset) so that the
   // first sample on a new map is never compared against a sample taken from
   // the old source.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         event_q <= 1'b0;
      end else begin
         prev_q  <= mux;
         armed_q <= ~commit_i;
         event_q <= event_d;
      end
   end

   assign event_o = event_q;

endmodule

// File: rtl/event_xbar.sv
// -----------------------------------------------------------------------------
// event_xbar
// Configurable PMU event crossbar. Routes any of N_IN SoC events to any of
// N_OUT counter inputs with a per-channel level / rise / fall / off mode.
// Config is written into a shadow copy and made active for all channels at
// once on a commit strobe.
// Ports:
//   clk_i, rstn_i   : clock, synchronous active-low reset
//   event_i         : SoC event vector (bit i = source i)
//   event_o         : registered routed events (bit x = counter x)
//   cfg_we_i        : shadow write strobe for channel cfg_idx_i
//   cfg_idx_i       : channel to write (>= N_OUT is ignored)
//   cfg_sel_i       : source select to write
//   cfg_mode_i      : mode to write (00 level, 01 rise, 10 fall, 11 off)
//   cfg_commit_i    : copy whole shadow map into the active map
//   cfg_pending_o   : a shadow write has happened since the last commit
//   rd_idx_i        : channel to read back
//   rd_sel_o        : active select of rd_idx_i, one cycle later
//   rd_mode_o       : active mode of rd_idx_i, one cycle later
// Strobe semantics: cfg_we_i and cfg_commit_i are single-cycle strobes with
// no back-pressure; each high cycle acts exactly once on that clock edge.
// A write and a commit on the same edge commit the written value.
// -----------------------------------------------------------------------------
module event_xbar
   import event_xbar_pkg::*;
#(
   parameter  int unsigned N_IN  = 32,
   parameter  int unsigned N_OUT = 24,
   localparam int unsigned SEL_W = $clog2(N_IN),
   localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [N_IN-1:0]  event_i,
   output logic [N_OUT-1:0] event_o,
   input  logic             cfg_we_i,
   input  logic [IDX_W-1:0] cfg_idx_i,
   input  logic [SEL_W-1:0] cfg_sel_i,
   input  logic [1:0]       cfg_mode_i,
   input  logic             cfg_commit_i,
   output logic             cfg_pending_o,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [SEL_W-1:0] rd_sel_o,
   output logic [1:0]       rd_mode_o
);

   localparam logic [IDX_W:0]          IDX_LIM = (IDX_W+1)'(N_OUT);
   localparam logic [XBAR_SEL_MAX_W:0] SEL_LIM = (XBAR_SEL_MAX_W+1)'(N_IN);

   xbar_cfg_t shadow_q [N_OUT];
   xbar_cfg_t shadow_d [N_OUT];
   xbar_cfg_t active_q [N_OUT];
   xbar_cfg_t wr_cfg;
   xbar_cfg_t rd_cfg;
   logic      write_hit;
   logic      pending_q;
   logic [SEL_W-1:0] rd_sel_d;
   logic [SEL_W-1:0] rd_sel_q;
   logic [1:0]       rd_mode_q;

   // Writes to a channel index past the last channel are dropped entirely.
   assign write_hit = cfg_we_i && ({1'b0, cfg_idx_i} < IDX_LIM);

   always_comb begin
      wr_cfg      = '0;
      wr_cfg.sel  = XBAR_SEL_MAX_W'(cfg_sel_i);
      wr_cfg.mode = xbar_mode_t'(cfg_mode_i);
   end

   // Readback mux: indexes past the last channel read as zero.
   always_comb begin
      rd_cfg = '0;
      for (int x = 0; x < int'(N_OUT); x++) begin
         if (rd_idx_i == IDX_W'(x)) begin
            rd_cfg = active_q[x];
         end
      end
   end

   // Stored selects always fit in SEL_W; the range guard keeps the upper
   // struct bits meaningful rather than silently truncated.
   assign rd_sel_d = ({1'b0, rd_cfg.sel} < SEL_LIM) ? rd_cfg.sel[SEL_W-1:0]
                                                     : '0;

   for (genvar x = 0; x < int'(N_OUT); x++) begin : g_ch
      // shadow_d already contains this cycle's write, so a same-edge commit
      // picks it up.
      assign shadow_d[x] = (write_hit && (cfg_idx_i == IDX_W'(x))) ? wr_cfg
                                                                   : shadow_q[x];

      event_xbar_ch #(
         .N_IN (N_IN)
      ) u_ch (
         .clk_i    (clk_i),
         .rstn_i   (rstn_i),
         .event_i  (event_i),
         .cfg_i    (active_q[x]),
         .commit_i (cfg_commit_i),
         .event_o  (event_o[x])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int unsigned x = 0; x < N_OUT; x++) begin
            shadow_q[x] <= xbar_reset_cfg(x, N_IN);
            active_q[x] <= xbar_reset_cfg(x, N_IN);
         end
         pending_q <= 1'b0;
         rd_sel_q  <= '0;
         rd_mode_q <= '0;
      end else begin
         for (int unsigned x = 0; x < N_OUT; x++) begin
            shadow_q[x] <= shadow_d[x];
            if (cfg_commit_i) begin
               active_q[x] <= shadow_d[x];
            end
         end
         // Commit wins over a same-edge write: the write is in the new map.
         if (cfg_commit_i) begin
            pending_q <= 1'b0;
         end else if (write_hit) begin
            pending_q <= 1'b1;
         end
         rd_sel_q  <= rd_sel_d;
         rd_mode_q <= rd_cfg.mode;
      end
   end

   assign cfg_pending_o = pending_q;
   assign rd_sel_o      = rd_sel_q;
   assign rd_mode_o     = rd_mode_q;

endmodule

// File: tb/tb_event_xbar.sv
// -----------------------------------------------------------------------------
// tb_event_xbar
// Directed table of vectors with hand-derived expectations, a toggle
// sequence, then randomized traffic against a reference model of the
// crossbar rules.
// -----------------------------------------------------------------------------
module tb_event_xbar;

   localparam int N_IN  = 32;
   localparam int N_OUT = 24;
   localparam int SEL_W = 5;
   localparam int IDX_W = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn_i = 1'b0;
   always #5 clk = ~clk;

   logic [N_IN-1:0]  event_i = '0;
   logic [N_OUT-1:0] event_o;
   logic             cfg_we_i = 1'b0;
   logic [IDX_W-1:0] cfg_idx_i = '0;
   logic [SEL_W-1:0] cfg_sel_i = '0;
   logic [1:0]       cfg_mode_i = '0;
   logic             cfg_commit_i = 1'b0;
   logic             cfg_pending_o;
   logic [IDX_W-1:0] rd_idx_i = '0;
   logic [SEL_W-1:0] rd_sel_o;
   logic [1:0]       rd_mode_o;

   event_xbar #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn_i),
      .event_i       (event_i),
      .event_o       (event_o),
      .cfg_we_i      (cfg_we_i),
      .cfg_idx_i     (cfg_idx_i),
      .cfg_sel_i     (cfg_sel_i),
      .cfg_mode_i    (cfg_mode_i),
      .cfg_commit_i  (cfg_commit_i),
      .cfg_pending_o (cfg_pending_o),
      .rd_idx_i      (rd_idx_i),
      .rd_sel_o      (rd_sel_o),
      .rd_mode_o     (rd_mode_o)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   // Maps are kept as plain integer arrays. An edge-mode channel reports a
   // transition only when the previous sample was taken on the same map
   // (not across a commit or a reset).
   int   m_act_sel  [N_OUT];
   int   m_act_mode [N_OUT];
   int   m_shd_sel  [N_OUT];
   int   m_shd_mode [N_OUT];
   bit   m_last     [N_OUT];
   bit   m_same_map [N_OUT];
   bit   m_pend;
   logic [N_OUT-1:0] m_exp_ev;
   int   m_exp_rd_sel;
   int   m_exp_rd_mode;

   logic [N_OUT-1:0] exp_q[$];

   task automatic model_edge(input logic rst_n, input logic [31:0] ev,
                             input logic we, input int idx, input int sel,
                             input int mode, input logic commit, input int rd);
      if (!rst_n) begin
         for (int x = 0; x < N_OUT; x++) begin
            m_act_sel[x]  = x % N_IN;  m_act_mode[x] = 0;
            m_shd_sel[x]  = x % N_IN;  m_shd_mode[x] = 0;
            m_last[x]     = 1'b0;      m_same_map[x] = 1'b0;
         end
         m_pend        = 1'b0;
         m_exp_ev      = '0;
         m_exp_rd_sel  = 0;
         m_exp_rd_mode = 0;
         return;
      end
      for (int x = 0; x < N_OUT; x++) begin
         bit s;
         bit o;
         s = (m_act_sel[x] < N_IN) ? ev[m_act_sel[x]] : 1'b0;
         case (m_act_mode[x])
            0:       o = s;
            1:       o = s && !m_last[x] && m_same_map[x];
            2:       o = !s && m_last[x] && m_same_map[x];
            default: o = 1'b0;
         endcase
         m_exp_ev[x]   = o;
         m_last[x]     = s;
         m_same_map[x] = 1'b1;
      end
      if (rd < N_OUT) begin
         m_exp_rd_sel  = m_act_sel[rd];
         m_exp_rd_mode = m_act_mode[rd];
      end else begin
         m_exp_rd_sel  = 0;
         m_exp_rd_mode = 0;
      end
      if (we && idx < N_OUT) begin
         m_shd_sel[idx]  = sel;
         m_shd_mode[idx] = mode;
         m_pend          = 1'b1;
      end
      if (commit) begin
         for (int x = 0; x < N_OUT; x++) begin
            m_act_sel[x]  = m_shd_sel[x];
            m_act_mode[x] = m_shd_mode[x];
            m_same_map[x] = 1'b0;
         end
         m_pend = 1'b0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Drives one cycle, lets the model predict it, then compares #1 after the
   // rising edge.
   task automatic step(input logic rst_n, input logic [31:0] ev,
                       input logic we, input int idx, input int sel,
                       input int mode, input logic commit, input int rd);
      logic [N_OUT-1:0] e;
      logic [31:0] idx_v, sel_v, mode_v, rd_v;
      idx_v = idx; sel_v = sel; mode_v = mode; rd_v = rd;
      rstn_i       = rst_n;
      event_i      = ev;
      cfg_we_i     = we;
      cfg_idx_i    = idx_v[IDX_W-1:0];
      cfg_sel_i    = sel_v[SEL_W-1:0];
      cfg_mode_i   = mode_v[1:0];
      cfg_commit_i = commit;
      rd_idx_i     = rd_v[IDX_W-1:0];
      model_edge(rst_n, ev, we, idx, sel, mode, commit, rd);
      exp_q.push_back(m_exp_ev);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("model_event_o", 32'(event_o), 32'(e));
      check("model_pending", 32'(cfg_pending_o), 32'(m_pend));
      check("model_rd_sel", 32'(rd_sel_o), m_exp_rd_sel);
      check("model_rd_mode", 32'(rd_mode_o), m_exp_rd_mode);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        rstn;
      logic [31:0] ev;
      logic        we;
      int          idx;
      int          sel;
      int          mode;
      logic        commit;
      int          rd;
      logic [23:0] exp_ev;
      logic        exp_pend;
      int          exp_rd_sel;
      int          exp_rd_mode;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic rstn, logic [31:0] ev, logic we, int idx,
                              int sel, int mode, logic commit, int rd,
                              logic [23:0] exp_ev, logic exp_pend,
                              int exp_rd_sel, int exp_rd_mode);
      vec_t r;
      r.rstn = rstn; r.ev = ev; r.we = we; r.idx = idx; r.sel = sel;
      r.mode = mode; r.commit = commit; r.rd = rd; r.exp_ev = exp_ev;
      r.exp_pend = exp_pend; r.exp_rd_sel = exp_rd_sel;
      r.exp_rd_mode = exp_rd_mode;
      return r;
   endfunction

   initial begin
      logic [31:0] ev_r;

      // identity map after reset
      vecs.push_back(v(1, 32'h00F0_000F, 0,  0,  0, 0, 0,  5, 24'hF0000F, 0,  5, 0));
      // shadow write ch3 -> src20, not yet active
      vecs.push_back(v(1, 32'h0000_0000, 1,  3, 20, 0, 0,  3, 24'h000000, 1,  3, 0));
      vecs.push_back(v(1, 32'h0010_0000, 0,  0,  0, 0, 0,  3, 24'h100000, 1,  3, 0));
      vecs.push_back(v(1, 32'h0010_0000, 0,  0,  0, 0, 1,  3, 24'h100000, 0,  3, 0));
      vecs.push_back(v(1, 32'h0010_0000, 0,  0,  0, 0, 0,  3, 24'h100008, 0, 20, 0));
      vecs.push_back(v(1, 32'h0000_0000, 0,  0,  0, 0, 0,  3, 24'h000000, 0, 20, 0));
      // ch0 rise on src7 (write+commit same cycle), hold high 5 cycles
      vecs.push_back(v(1, 32'h0000_0000, 1,  0,  7, 1, 1,  0, 24'h000000, 0,  0, 0));
      vecs.push_back(v(1, 32'h0000_0000, 0,  0,  0, 0, 0,  0, 24'h000000, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000081, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000080, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000080, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000080, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000080, 0,  7, 1));
      // switch ch0 to fall, then drop src7
      vecs.push_back(v(1, 32'h0000_0080, 1,  0,  7, 2, 1,  0, 24'h000080, 0,  7, 1));
      vecs.push_back(v(1, 32'h0000_0080, 0,  0,  0, 0, 0,  0, 24'h000080, 0,  7, 2));
      vecs.push_back(v(1, 32'h0000_0000, 0,  0,  0, 0, 0,  0, 24'h000001, 0,  7, 2));
      vecs.push_back(v(1, 32'h0000_0000, 0,  0,  0, 0, 0,  0, 24'h000000, 0,  7, 2));
      // out-of-range channel write is ignored; out-of-range readback is 0
      vecs.push_back(v(1, 32'h0000_0000, 1, 30,  9, 3, 0, 30, 24'h000000, 0,  0, 0));
      // ch1 rise: low source 4, then switch to already-high source 5
      vecs.push_back(v(1, 32'h0000_0000, 1,  1,  4, 1, 1,  1, 24'h000000, 0,  1, 0));
      vecs.push_back(v(1, 32'h0000_0020, 0,  0,  0, 0, 0,  1, 24'h000020, 0,  4, 1));
      vecs.push_back(v(1, 32'h0000_0020, 1,  1,  5, 1, 1,  1, 24'h000020, 0,  4, 1));
      vecs.push_back(v(1, 32'h0000_0020, 0,  0,  0, 0, 0,  1, 24'h000020, 0,  5, 1));
      vecs.push_back(v(1, 32'h0000_0000, 0,  0,  0, 0, 0,  1, 24'h000000, 0,  5, 1));
      vecs.push_back(v(1, 32'h0000_0020, 0,  0,  0, 0, 0,  1, 24'h000022, 0,  5, 1));
      // write+commit on ch2 -> level on src5
      vecs.push_back(v(1, 32'h0000_0020, 1,  2,  5, 0, 1,  2, 24'h000020, 0,  2, 0));
      vecs.push_back(v(1, 32'h0000_0020, 0,  0,  0, 0, 0,  2, 24'h000024, 0,  5, 0));
      // ch5 disabled
      vecs.push_back(v(1, 32'h0000_0020, 1,  5,  5, 3, 1,  5, 24'h000024, 0,  5, 0));
      vecs.push_back(v(1, 32'h0000_0020, 0,  0,  0, 0, 0,  5, 24'h000004, 0,  5, 3));
      // pending shadow write, then reset pulse discards it
      vecs.push_back(v(1, 32'h0000_0000, 1,  4,  0, 0, 0,  4, 24'h000000, 1,  4, 0));
      vecs.push_back(v(0, 32'hFFFF_FFFF, 0,  0,  0, 0, 0,  4, 24'h000000, 0,  0, 0));
      vecs.push_back(v(1, 32'h0000_0010, 0,  0,  0, 0, 1,  4, 24'h000010, 0,  4, 0));
      vecs.push_back(v(1, 32'h0000_0010, 0,  0,  0, 0, 0,  4, 24'h000010, 0,  4, 0));

      // reset for two cycles
      step(0, 32'h0, 0, 0, 0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 0);
      check("reset_event_o", 32'(event_o), 32'h0);
      check("reset_pending", 32'(cfg_pending_o), 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rstn, vecs[i].ev, vecs[i].we, vecs[i].idx, vecs[i].sel,
              vecs[i].mode, vecs[i].commit, vecs[i].rd);
         check($sformatf("tbl%0d_event_o", i), 32'(event_o), 32'(vecs[i].exp_ev));
         check($sformatf("tbl%0d_pending", i), 32'(cfg_pending_o), 32'(vecs[i].exp_pend));
         check($sformatf("tbl%0d_rd_sel", i), 32'(rd_sel_o), vecs[i].exp_rd_sel);
         check($sformatf("tbl%0d_rd_mode", i), 32'(rd_mode_o), vecs[i].exp_rd_mode);
      end

      // back-to-back toggles on a rise channel: pulse on every 0->1
      step(1, 32'h0, 1, 6, 9, 1, 1, 6);
      step(1, 32'h0, 0, 0, 0, 0, 0, 6);
      for (int k = 0; k < 6; k++) begin
         step(1, (k % 2 == 0) ? 32'h0000_0200 : 32'h0, 0, 0, 0, 0, 0, 6);
         check($sformatf("toggle%0d_ch6", k), 32'(event_o[6]),
               (k % 2 == 0) ? 32'd1 : 32'd0);
      end

      // randomized traffic
      ev_r = $urandom;
      for (int n = 0; n < 3000; n++) begin
         logic rn;
         rn = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 1) == 1) ev_r = $urandom;
         else if ($urandom_range(0, 1) == 1) ev_r = ev_r ^ (32'h1 << $urandom_range(0, 31));
         step(rn, ev_r, ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0), $urandom_range(0, 31));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
